// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter.
// Funct3 encodings, FSM/owner enums and the default memory size.
package dmem_pkg;

  localparam int DMEM_BYTES = 20480;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_EXT
  } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the data-memory arbiter.
// master = requester side, slave = arbiter side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic [2:0]        func3;
  logic              rsp_valid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req_valid, addr, wdata, we, func3,
    input  req_ready, rsp_valid, rdata, err
  );

  modport slave (
    input  req_valid, addr, wdata, we, func3,
    output req_ready, rsp_valid, rdata, err
  );

endinterface

// File: rtl/dmem_access_check.sv
// dmem_access_check: combinational legality check of one access.
// Flags out-of-range, misaligned and unsupported-funct3 accesses.
module dmem_access_check
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = DMEM_BYTES
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [2:0]        func3,
  output logic              legal
);

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_BYTES);

  logic range_bad;
  logic half_bad;
  logic word_bad;
  logic f3_bad;

  // Each rule is evaluated independently and any hit blocks the access.
  always_comb begin
    range_bad = (addr >= LIMIT);
    half_bad  = (func3[1:0] == 2'b01) && addr[0];
    word_bad  = (func3[1:0] == 2'b10) && (addr[1:0] != 2'b00);
    if (we) begin
      f3_bad = !(func3 inside {F3_B, F3_H, F3_W});
    end else begin
      f3_bad = !(func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
    legal = !(range_bad | half_bad | word_bad | f3_bad);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin CPU/loader arbiter for the data memory.
// Accept in IDLE, drive memory in ACCESS, respond the cycle after.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = DMEM_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     cpu,
  dmem_arbiter_if.slave     ext,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [2:0]        mem_func3,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t            state;
  owner_t            last_grant;
  owner_t            own;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_we;
  logic [2:0]        l_f3;
  logic              legal;
  logic              grant_cpu;
  logic              grant_ext;
  logic [DATA_W-1:0] rsp_data;

  dmem_access_check #(
    .ADDR_W    (ADDR_W),
    .MEM_BYTES (MEM_BYTES)
  ) u_check (
    .addr  (l_addr),
    .we    (l_we),
    .func3 (l_f3),
    .legal (legal)
  );

  // Round robin: on a tie the port that did not win last time goes.
  always_comb begin
    grant_cpu = cpu.req_valid &
                (!ext.req_valid | (last_grant == OWN_EXT));
    grant_ext = ext.req_valid & !grant_cpu;
  end

  // Ready only in IDLE and never while reset is held.
  assign cpu.req_ready = reset & (state == IDLE) & grant_cpu;
  assign ext.req_ready = reset & (state == IDLE) & grant_ext;

  // Memory is driven only during ACCESS; writes need a legal access.
  always_comb begin
    busy      = (state == ACCESS);
    mem_addr  = busy ? l_addr  : '0;
    mem_wdata = busy ? l_wdata : '0;
    mem_func3 = busy ? l_f3    : '0;
    mem_we    = busy & l_we & legal;
    rsp_data  = (l_we | !legal) ? '0 : mem_rdata;
  end

  // Sequencer: latch winner, run one access, post owner response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_grant    <= OWN_EXT;
      own           <= OWN_CPU;
      l_addr        <= '0;
      l_wdata       <= '0;
      l_we          <= 1'b0;
      l_f3          <= '0;
      cpu.rsp_valid <= 1'b0;
      cpu.rdata     <= '0;
      cpu.err       <= 1'b0;
      ext.rsp_valid <= 1'b0;
      ext.rdata     <= '0;
      ext.err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cpu.rsp_valid <= 1'b0;
          ext.rsp_valid <= 1'b0;
          if (cpu.req_ready | ext.req_ready) begin
            l_addr     <= grant_cpu ? cpu.addr  : ext.addr;
            l_wdata    <= grant_cpu ? cpu.wdata : ext.wdata;
            l_we       <= grant_cpu ? cpu.we    : ext.we;
            l_f3       <= grant_cpu ? cpu.func3 : ext.func3;
            own        <= grant_cpu ? OWN_CPU   : OWN_EXT;
            last_grant <= grant_cpu ? OWN_CPU   : OWN_EXT;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          state <= IDLE;
          if (own == OWN_CPU) begin
            cpu.rsp_valid <= 1'b1;
            cpu.rdata     <= rsp_data;
            cpu.err       <= !legal;
          end else begin
            ext.rsp_valid <= 1'b1;
            ext.rdata     <= rsp_data;
            ext.err       <= !legal;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed + random checks against a transaction model.
// Bench owns a behavioural memory and a separate reference byte image.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int MB = 20480;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [2:0]  mem_func3;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) cpu_if ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ext_if ();

  dmem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MEM_BYTES (MB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu_if),
    .ext       (ext_if),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_func3 (mem_func3),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit          port;
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    logic [2:0]  f;
    int          cyc;
  } txn_t;

  txn_t        pend;
  bit          pend_v = 0;
  bit          m_last = 1;
  bit          acc_c = 0;
  bit          acc_e = 0;
  int          glog[$];
  logic [7:0]  mem [MB];
  logic [7:0]  ref_mem [MB];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_legal(input txn_t t);
    if (t.a >= 32'(MB)) return 0;
    if (t.f[1:0] == 2'b01 && t.a[0]) return 0;
    if (t.f[1:0] == 2'b10 && t.a[1:0] != 2'b00) return 0;
    if (t.w && t.f > 3'd2) return 0;
    if (!t.w && (t.f == 3'd3 || t.f == 3'd6 || t.f == 3'd7)) return 0;
    return 1;
  endfunction

  task automatic ref_commit(input txn_t t, output logic [31:0] rd,
                            output logic er);
    int nb;
    logic [31:0] v;
    rd = '0;
    er = 1'b0;
    if (!ref_legal(t)) begin
      er = 1'b1;
      return;
    end
    nb = 1 << t.f[1:0];
    if (t.w) begin
      for (int i = 0; i < nb; i++) ref_mem[t.a + i] = t.d[8*i +: 8];
      return;
    end
    v = '0;
    for (int i = 0; i < nb; i++)
      v = v | (32'(ref_mem[t.a + i]) << (8 * i));
    if (!t.f[2] && nb < 4 && v[8*nb-1])
      v = v | ~((32'd1 << (8 * nb)) - 32'd1);
    rd = v;
  endtask

  function automatic logic [31:0] env_read(input logic [31:0] a,
                                           input logic [2:0] f);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++)
      if (longint'(a) + i < MB) w[8*i +: 8] = mem[a + i];
    case (f)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd4:    return {24'b0, w[7:0]};
      3'd5:    return {16'b0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Behavioural single-port memory.
  always @(posedge clk) begin
    cyc++;
    if (mem_we)
      for (int i = 0; i < (1 << mem_func3[1:0]); i++)
        if (longint'(mem_addr) + i < MB)
          mem[mem_addr + i] = mem_wdata[8*i +: 8];
  end

  // Read data settles mid-cycle, stable by the sampling edge.
  always @(negedge clk) mem_rdata = env_read(mem_addr, mem_func3);

  // Scoreboard: predict grants, strobes and responses each cycle.
  always @(negedge clk) begin
    logic [31:0] rd;
    logic        er;
    bit          in_acc;
    bit          ec;
    bit          ee;
    if (!reset) begin
      pend_v = 0;
      m_last = 1;
      acc_c  = 0;
      acc_e  = 0;
      check("rst_ctl", {cpu_if.req_ready, ext_if.req_ready,
                        cpu_if.rsp_valid, ext_if.rsp_valid,
                        cpu_if.err, ext_if.err, mem_we, busy}, '0);
      check("rst_data", cpu_if.rdata | ext_if.rdata | mem_addr |
                        mem_wdata | 32'(mem_func3), '0);
    end else begin
      in_acc = pend_v && pend.cyc == cyc - 1;
      if (pend_v && pend.cyc == cyc - 2) begin
        ref_commit(pend, rd, er);
        if (!pend.port) begin
          check("cpu_rsp_v", cpu_if.rsp_valid, 1);
          check("cpu_rdata", cpu_if.rdata, rd);
          check("cpu_err", cpu_if.err, er);
          check("ext_rsp_quiet", ext_if.rsp_valid, 0);
        end else begin
          check("ext_rsp_v", ext_if.rsp_valid, 1);
          check("ext_rdata", ext_if.rdata, rd);
          check("ext_err", ext_if.err, er);
          check("cpu_rsp_quiet", cpu_if.rsp_valid, 0);
        end
        pend_v = 0;
      end else begin
        check("rsp_quiet", {cpu_if.rsp_valid, ext_if.rsp_valid}, 0);
      end
      check("busy", busy, in_acc);
      check("mem_we", mem_we, in_acc && pend.w && ref_legal(pend));
      if (in_acc) check("mem_addr", mem_addr, pend.a);
      else check("mem_idle", mem_addr | mem_wdata | 32'(mem_func3), 0);
      ec = !in_acc && cpu_if.req_valid && (!ext_if.req_valid || m_last);
      ee = !in_acc && ext_if.req_valid && !ec;
      check("ready", {cpu_if.req_ready, ext_if.req_ready}, {ec, ee});
      acc_c = cpu_if.req_valid && cpu_if.req_ready;
      acc_e = ext_if.req_valid && ext_if.req_ready;
      if (acc_c || acc_e) glog.push_back(acc_e ? 1 : 0);
      if (ec || ee) begin
        pend.port = ee;
        pend.a    = ee ? ext_if.addr  : cpu_if.addr;
        pend.d    = ee ? ext_if.wdata : cpu_if.wdata;
        pend.w    = ee ? ext_if.we    : cpu_if.we;
        pend.f    = ee ? ext_if.func3 : cpu_if.func3;
        pend.cyc  = cyc;
        pend_v    = 1;
        m_last    = ee;
      end
    end
  end

  task automatic set_port(input bit p, input bit v, input logic [31:0] a,
                          input logic [31:0] d, input logic w,
                          input logic [2:0] f);
    if (!p) begin
      cpu_if.req_valid = v; cpu_if.addr = a; cpu_if.wdata = d;
      cpu_if.we = w; cpu_if.func3 = f;
    end else begin
      ext_if.req_valid = v; ext_if.addr = a; ext_if.wdata = d;
      ext_if.we = w; ext_if.func3 = f;
    end
  endtask

  task automatic drop(input bit p);
    if (!p) cpu_if.req_valid = 1'b0;
    else ext_if.req_valid = 1'b0;
  endtask

  function automatic bit p_ready(input bit p);
    return p ? ext_if.req_ready : cpu_if.req_ready;
  endfunction

  function automatic bit p_rsp(input bit p);
    return p ? ext_if.rsp_valid : cpu_if.rsp_valid;
  endfunction

  task automatic issue(input bit p, input logic [31:0] a,
                       input logic [31:0] d, input logic w,
                       input logic [2:0] f, output logic [31:0] rd,
                       output logic er);
    int n;
    @(posedge clk); #1;
    set_port(p, 1'b1, a, d, w, f);
    n = 0;
    do begin @(negedge clk); n++; end while (!p_ready(p) && n < 20);
    check("accepted", p_ready(p), 1);
    @(posedge clk); #1;
    drop(p);
    n = 0;
    do begin @(negedge clk); n++; end while (!p_rsp(p) && n < 6);
    check("rsp_latency", n, 2);
    rd = p ? ext_if.rdata : cpu_if.rdata;
    er = p ? ext_if.err : cpu_if.err;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 32'h100 + 32'($urandom_range(0, 31));
    if (r < 8) return 32'(MB - 8) + 32'($urandom_range(0, 15));
    if (r == 8) return $urandom;
    return 32'h200 + 32'(4 * $urandom_range(0, 3));
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] top_word;
    logic [7:0]  b;
    int          n;

    for (int i = 0; i < MB; i++) begin
      b = 8'($urandom);
      mem[i] = b;
      ref_mem[i] = b;
    end

    set_port(0, 1'b1, 32'h0, 32'h0, 1'b0, F3_W);
    set_port(1, 1'b1, 32'h4, 32'h0, 1'b0, F3_W);
    repeat (3) @(negedge clk);
    check("rst_ready", {cpu_if.req_ready, ext_if.req_ready}, 0);
    check("rst_we", mem_we, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("first_grant", {cpu_if.req_ready, ext_if.req_ready}, 2'b10);
    @(posedge clk); #1;
    drop(0);
    drop(1);
    repeat (4) @(negedge clk);

    issue(0, 32'h100, 32'hDEADBEEF, 1'b1, F3_W, rd, er);
    check("sw_err", er, 0);
    issue(0, 32'h100, 32'h0, 1'b0, F3_W, rd, er);
    check("lw_data", rd, 32'hDEADBEEF);
    check("lw_err", er, 0);

    issue(1, 32'h103, 32'h123456A5, 1'b1, F3_B, rd, er);
    check("sb_err", er, 0);
    issue(0, 32'h103, 32'h0, 1'b0, F3_BU, rd, er);
    check("lbu_data", rd, 32'h000000A5);
    issue(0, 32'h103, 32'h0, 1'b0, F3_B, rd, er);
    check("lb_data", rd, 32'hFFFFFFA5);
    issue(0, 32'h100, 32'h0, 1'b0, F3_W, rd, er);
    check("sb_merge", rd, 32'hA5ADBEEF);

    issue(1, 32'h0, 32'h0, 1'b0, F3_W, rd, er);
    glog.delete();
    @(posedge clk); #1;
    set_port(0, 1'b1, 32'h100, 32'h0, 1'b0, F3_W);
    set_port(1, 1'b1, 32'h104, 32'h0, 1'b0, F3_W);
    n = 0;
    while (glog.size() < 4 && n < 40) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    drop(0);
    drop(1);
    check("cont_count", glog.size(), 4);
    for (int i = 0; i < 4; i++)
      check("cont_grant", (i < glog.size()) ? glog[i] : 32'hF, i % 2);
    repeat (4) @(negedge clk);

    issue(0, 32'h102, 32'h0, 1'b0, F3_W, rd, er);
    check("lw_mis_err", er, 1);
    check("lw_mis_data", rd, 0);
    top_word = {mem[MB-1], mem[MB-2], mem[MB-3], mem[MB-4]};
    issue(0, 32'h5000, 32'h12345678, 1'b1, F3_W, rd, er);
    check("sw_range_err", er, 1);
    issue(0, 32'h4FFC, 32'h0, 1'b0, F3_W, rd, er);
    check("top_word", rd, top_word);
    check("top_err", er, 0);

    issue(0, 32'h200, 32'h11111111, 1'b1, F3_W, rd, er);
    @(posedge clk); #1;
    set_port(0, 1'b1, 32'h200, 32'h22222222, 1'b1, F3_W);
    @(negedge clk);
    check("mw_ready", cpu_if.req_ready, 1);
    @(posedge clk); #1;
    drop(0);
    check("mw_we_on", mem_we, 1);
    #1 reset = 1'b0;
    #1;
    check("mw_we_drop", mem_we, 0);
    check("mw_busy_drop", busy, 0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    issue(0, 32'h200, 32'h0, 1'b0, F3_W, rd, er);
    check("mw_kept", rd, 32'h11111111);

    repeat (600) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        bit v;
        bit acc;
        v   = p[0] ? ext_if.req_valid : cpu_if.req_valid;
        acc = p[0] ? acc_e : acc_c;
        if (!v || acc) begin
          if ($urandom_range(0, 99) < 55)
            set_port(p[0], 1'b1, rand_addr(), $urandom,
                     1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
          else
            drop(p[0]);
        end else if ($urandom_range(0, 99) < 4) begin
          drop(p[0]);
        end
      end
    end
    @(posedge clk); #1;
    drop(0);
    drop(1);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
